// File: rtl/loader_pkg.sv
// Shared types and header field positions for the memory loader.
// Optional feature macro used by mem_loader: LOADER_CHECKSUM_EN.
package loader_pkg;

   typedef enum logic [1:0] {
      TGT_IMEM  = 2'd0,
      TGT_MAT_A = 2'd1,
      TGT_MAT_B = 2'd2,
      TGT_GO    = 2'd3
   } tgt_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      CHK     = 3'd2,
      START   = 3'd3,
      WAIT_LO = 3'd4,
      WAIT_HI = 3'd5
   } state_e;

   // Header word layout: [31:30] target, [27:16] base, [15:0] count.
   localparam int TGT_MSB  = 31;
   localparam int TGT_LSB  = 30;
   localparam int BASE_MSB = 27;
   localparam int BASE_LSB = 16;
   localparam int CNT_MSB  = 15;
   localparam int CNT_LSB  = 0;

   // True when the target is the instruction memory (the deeper RAM).
   function automatic logic is_imem(input tgt_e t);
      return (t == TGT_IMEM);
   endfunction

endpackage

// File: rtl/mem_loader.sv
// Host-side memory loader: turns a 32-bit valid/ready command stream into
// port-A writes for imem / mat_a / mat_b and runs the processor on GO.
// Define LOADER_CHECKSUM_EN to require an XOR trailer word after each load.
module mem_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned IMEM_WORDS = 2048,
   parameter int unsigned DMEM_WORDS = 1024,
   parameter int unsigned DATA_LEN   = 32
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [DATA_LEN-1:0] s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [DATA_LEN-1:0] wr_data,
   output logic                imem_we,
   output logic                mat_a_we,
   output logic                mat_b_we,
   output logic                proc_start,
   input  logic                proc_stop,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam logic [ADDR_W-1:0] IMEM_MASK = ADDR_W'(IMEM_WORDS - 1);
   localparam logic [ADDR_W-1:0] DMEM_MASK = ADDR_W'(DMEM_WORDS - 1);

   // Address wrap mask for the selected RAM.
   function automatic logic [ADDR_W-1:0] depth_mask(input tgt_e t);
      return is_imem(t) ? IMEM_MASK : DMEM_MASK;
   endfunction

   state_e                state_q, state_d;
   tgt_e                  tgt_q, tgt_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
   logic [DATA_LEN-1:0]   wr_data_q, wr_data_d;
   logic                  imem_we_q, imem_we_d;
   logic                  mat_a_we_q, mat_a_we_d;
   logic                  mat_b_we_q, mat_b_we_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  ready_q, busy_q, start_q;
   logic                  ready_s;
   tgt_e                  hdr_tgt_s;
   logic [ADDR_W-1:0]     hdr_base_s;
   logic [15:0]           hdr_cnt_s;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_LEN-1:0]   csum_q, csum_d;
`endif

   assign ready_s    = ready_q;
   assign hdr_tgt_s  = tgt_e'(s_data[TGT_MSB:TGT_LSB]);
   assign hdr_base_s = ADDR_W'(s_data[BASE_MSB:BASE_LSB]);
   assign hdr_cnt_s  = s_data[CNT_MSB:CNT_LSB];

   // Next-state and registered-output decisions for the command FSM.
   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      imem_we_d  = 1'b0;
      mat_a_we_d = 1'b0;
      mat_b_we_d = 1'b0;
      done_d     = 1'b0;
      err_d      = err_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (s_valid && ready_s) begin
               if (hdr_tgt_s == TGT_GO) begin
                  state_d = START;
               end else if (hdr_cnt_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = CHK;
                  csum_d  = '0;
`else
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d = LOAD;
                  tgt_d   = hdr_tgt_s;
                  addr_d  = hdr_base_s & depth_mask(hdr_tgt_s);
                  cnt_d   = hdr_cnt_s;
`ifdef LOADER_CHECKSUM_EN
                  csum_d  = '0;
`endif
               end
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (s_valid && ready_s) begin
               wr_addr_d = addr_q;
               wr_data_d = s_data;
               case (tgt_q)
                  TGT_IMEM:  imem_we_d  = 1'b1;
                  TGT_MAT_A: mat_a_we_d = 1'b1;
                  TGT_MAT_B: mat_b_we_d = 1'b1;
                  default:   imem_we_d  = 1'b0;
               endcase
               addr_d = (addr_q + ADDR_W'(1)) & depth_mask(tgt_q);
               cnt_d  = cnt_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ s_data;
`endif
               if (cnt_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = CHK;
`else
                  state_d = IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d = LOAD;
               end
            end else begin
               state_d = LOAD;
            end
         end
         CHK: begin
`ifdef LOADER_CHECKSUM_EN
            if (s_valid && ready_s) begin
               if (s_data != csum_q) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = CHK;
            end
`else
            state_d = IDLE;
`endif
         end
         START: begin
            state_d = WAIT_LO;
         end
         WAIT_LO: begin
            // A stop still high from the previous run must drop first.
            if (!proc_stop) begin
               state_d = WAIT_HI;
            end else begin
               state_d = WAIT_LO;
            end
         end
         WAIT_HI: begin
            if (proc_stop) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = WAIT_HI;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state, load counters and all registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         tgt_q      <= TGT_IMEM;
         addr_q     <= '0;
         cnt_q      <= 16'd0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         imem_we_q  <= 1'b0;
         mat_a_we_q <= 1'b0;
         mat_b_we_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         imem_we_q  <= imem_we_d;
         mat_a_we_q <= mat_a_we_d;
         mat_b_we_q <= mat_b_we_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ready_q    <= (state_d == IDLE) || (state_d == LOAD) || (state_d == CHK);
         busy_q     <= (state_d != IDLE);
         start_q    <= (state_d == START);
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running XOR of the payload words of the current load.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end
`endif

   assign s_ready    = ready_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign imem_we    = imem_we_q;
   assign mat_a_we   = mat_a_we_q;
   assign mat_b_we   = mat_b_we_q;
   assign proc_start = start_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
